// File: rtl/strobe_level_fifo.sv
// Quantizes 8-bit strobe samples into 2-bit levels and buffers them in a
// first-word-fall-through FIFO with a registered head and saturating event counters.
module strobe_level_fifo #(
  parameter int         AW = 4,
  parameter logic [7:0] T1 = 8'd64,
  parameter logic [7:0] T2 = 8'd128,
  parameter logic [7:0] T3 = 8'd192,
  parameter int         CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sample_valid,
  input  logic [7:0]    sample,
  input  logic          data_next,
  input  logic          clr_counts,
  output logic [1:0]    data_vals,
  output logic [AW:0]   fifo_level,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic [CW-1:0] ovf_count,
  output logic [CW-1:0] udr_count
);

  localparam int            DEPTH   = 1 << AW;
  localparam logic [AW:0]   PTR_ONE = 1;
  localparam logic [AW-1:0] IDX_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [1:0]    data_vals_q, data_vals_d;
  logic [CW-1:0] ovf_q, ovf_d;
  logic [CW-1:0] udr_q, udr_d;
  logic [1:0]    mem_q [DEPTH];

  logic [1:0]    level_in;
  logic [AW:0]   fill;
  logic [AW-1:0] rd_next_idx;
  logic          empty, full, pop_ok, push_ok, ovf_evt, udr_evt;

  assign fill        = wr_ptr_q - rd_ptr_q;
  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok      = data_next & ~empty;
  assign push_ok     = sample_valid & (~full | pop_ok);
  assign ovf_evt     = sample_valid & full & ~pop_ok;
  assign udr_evt     = data_next & empty;
  assign rd_next_idx = rd_ptr_q[AW-1:0] + IDX_ONE;

  always_comb begin
    if (sample < T1)      level_in = 2'b00;
    else if (sample < T2) level_in = 2'b01;
    else if (sample < T3) level_in = 2'b10;
    else                  level_in = 2'b11;
  end

  always_comb begin
    wr_ptr_d    = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    data_vals_d = data_vals_q;
    // Head only moves on a pop or when the first word lands in an empty FIFO.
    if (pop_ok) begin
      if (fill == PTR_ONE) data_vals_d = push_ok ? level_in : 2'b00;
      else                 data_vals_d = mem_q[rd_next_idx];
    end else if (empty && push_ok) begin
      data_vals_d = level_in;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    udr_d = udr_q;
    if (clr_counts) begin
      ovf_d = '0;
      udr_d = '0;
    end else begin
      if (ovf_evt && (ovf_q != '1)) ovf_d = ovf_q + CNT_ONE;
      if (udr_evt && (udr_q != '1)) udr_d = udr_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      data_vals_q <= 2'b00;
      ovf_q       <= '0;
      udr_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      data_vals_q <= data_vals_d;
      ovf_q       <= ovf_d;
      udr_q       <= udr_d;
    end
  end

  // Storage is not reset: zeroed pointers already make every old entry unreachable.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= level_in;
  end

  assign data_vals  = data_vals_q;
  assign fifo_level = fill;
  assign fifo_empty = empty;
  assign fifo_full  = full;
  assign ovf_count  = ovf_q;
  assign udr_count  = udr_q;

endmodule

// File: tb/tb_strobe_level_fifo.sv
// Scoreboard bench for strobe_level_fifo: expected levels are queued on push and
// compared against data_vals on pop; occupancy and counters come from a small model.
module tb_strobe_level_fifo;

  localparam int DEPTH = 16;
  localparam int MAXC  = 255;

  logic       clk;
  logic       rst_n;
  logic       sample_valid;
  logic [7:0] sample;
  logic       data_next;
  logic       clr_counts;
  logic [1:0] data_vals;
  logic [4:0] fifo_level;
  logic       fifo_empty;
  logic       fifo_full;
  logic [7:0] ovf_count;
  logic [7:0] udr_count;

  int tests_run = 0;
  int tests_failed = 0;
  int model_ovf = 0;
  int model_udr = 0;
  logic [1:0] sb[$];

  strobe_level_fifo u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample       (sample),
    .data_next    (data_next),
    .clr_counts   (clr_counts),
    .data_vals    (data_vals),
    .fifo_level   (fifo_level),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .ovf_count    (ovf_count),
    .udr_count    (udr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // With thresholds 64/128/192 the level is simply the top two sample bits.
  function automatic logic [1:0] quant(input logic [7:0] s);
    return s[7:6];
  endfunction

  task automatic check_state(input string tag);
    logic [1:0] exp_head;
    exp_head = (sb.size() > 0) ? sb[0] : 2'b00;
    check({tag, "_level"}, 32'(fifo_level), 32'(sb.size()));
    check({tag, "_empty"}, 32'(fifo_empty), 32'(sb.size() == 0));
    check({tag, "_full"},  32'(fifo_full),  32'(sb.size() == DEPTH));
    check({tag, "_head"},  32'(data_vals),  32'(exp_head));
    check({tag, "_ovf"},   32'(ovf_count),  32'(model_ovf));
    check({tag, "_udr"},   32'(udr_count),  32'(model_udr));
  endtask

  // One clock cycle of stimulus; called just after a rising edge.
  task automatic step(input logic v, input logic [7:0] s, input logic n, input logic c);
    logic [1:0] exp_head;
    sample_valid = v;
    sample       = s;
    data_next    = n;
    clr_counts   = c;
    if (n) begin
      if (sb.size() > 0) begin
        exp_head = sb.pop_front();
        check("pop_head", 32'(data_vals), 32'(exp_head));
      end else begin
        check("udr_head", 32'(data_vals), 32'd0);
        if (model_udr < MAXC) model_udr++;
      end
    end
    if (v) begin
      if (sb.size() < DEPTH) sb.push_back(quant(s));
      else if (model_ovf < MAXC) model_ovf++;
    end
    if (c) begin
      model_ovf = 0;
      model_udr = 0;
    end
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    data_next    = 1'b0;
    clr_counts   = 1'b0;
    $display("[TB] v=%0b s=%0d n=%0b c=%0b -> level=%0d head=%0d ovf=%0d udr=%0d",
             v, s, n, c, fifo_level, data_vals, ovf_count, udr_count);
    check_state("step");
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    sample_valid = 1'b0;
    sample = 8'd0;
    data_next = 1'b0;
    clr_counts = 1'b0;
    #12;
    check_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Quantization boundaries, then drain (multi-cycle data_next = one pop per cycle)
    step(1, 8'd63, 0, 0);
    step(1, 8'd64, 0, 0);
    step(1, 8'd191, 0, 0);
    step(1, 8'd255, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 8'd0, 1, 0);
    step(0, 8'd0, 0, 0);

    // Underruns while empty, then push+pop on an empty FIFO
    for (int i = 0; i < 3; i++) step(0, 8'd0, 1, 0);
    check("udr3", 32'(udr_count), 32'd3);
    step(1, 8'd200, 1, 0);
    check("udr4", 32'(udr_count), 32'd4);
    check("udr4_level", 32'(fifo_level), 32'd1);
    step(0, 8'd0, 1, 0);

    // Fill with 18 samples, no pops: two dropped
    for (int i = 0; i < 18; i++) step(1, 8'(i * 14 + 3), 0, 0);
    check("fill_ovf", 32'(ovf_count), 32'd2);
    check("fill_full", 32'(fifo_full), 32'd1);

    // Full + simultaneous push/pop: accepted, no overflow
    step(1, 8'd250, 1, 0);
    check("fullpp_level", 32'(fifo_level), 32'd16);
    check("fullpp_ovf", 32'(ovf_count), 32'd2);
    for (int i = 0; i < 15; i++) step(0, 8'd0, 1, 0);
    check("last_entry", 32'(data_vals), 32'd3);
    step(0, 8'd0, 1, 0);

    // Reset mid-stream with five entries queued and counters non-zero
    for (int i = 0; i < 5; i++) step(1, 8'(70 + i * 40), 0, 0);
    #3;
    rst_n = 1'b0;
    sb.delete();
    model_ovf = 0;
    model_udr = 0;
    #1;
    check_state("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 8'd130, 0, 0);
    step(0, 8'd0, 1, 0);

    // Saturation of the underrun counter, then clear beating a same-cycle underrun
    for (int i = 0; i < 260; i++) step(0, 8'd0, 1, 0);
    check("udr_sat", 32'(udr_count), 32'd255);
    step(0, 8'd0, 1, 1);
    check("clr_prio", 32'(udr_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
